// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the default geometry, the data width and the controller state encoding.
package icache_pkg;

  localparam int unsigned ICACHE_INDEX_BITS = 6;
  localparam int unsigned XLEN              = 32;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_MISS = 2'd1,
    IC_RESP = 2'd2
  } ic_state_e;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and MemCtrl-side handshake bundle of the instruction cache.
// The cache uses the slave view; fetch/MemCtrl (or a bench) use the master view.
interface icache_if;
  import icache_pkg::*;

  logic            if_req;
  logic [XLEN-1:0] if_pc;
  logic            if_ready;
  logic            if_valid;
  logic [XLEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc_out;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_data;
  logic            mem_done;

  modport slave (
    input  if_req, if_pc, mem_data, mem_done,
    output if_ready, if_valid, if_inst, if_pc_out, mem_req, mem_addr
  );

  modport master (
    output if_req, if_pc, mem_data, mem_done,
    input  if_ready, if_valid, if_inst, if_pc_out, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_line_ram.sv
// Line storage: {tag, data} per line with async read and sync write.
// Valid bits sit beside the array and are the only reset state.
module icache_line_ram
  import icache_pkg::*;
#(
  parameter  int unsigned INDEX_BITS = ICACHE_INDEX_BITS,
  localparam int unsigned TAG_W      = 30 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] waddr,
  input  logic [TAG_W-1:0]      wtag,
  input  logic [XLEN-1:0]       wdata,
  input  logic [INDEX_BITS-1:0] raddr,
  output logic                  rvalid,
  output logic [TAG_W-1:0]      rtag,
  output logic [XLEN-1:0]       rdata
);

  localparam int unsigned LINES  = 1 << INDEX_BITS;
  localparam int unsigned LINE_W = TAG_W + XLEN;

  logic [LINE_W-1:0] lines_q [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;

  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[waddr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag/data carry no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (we) lines_q[waddr] <= {wtag, wdata};
  end

  assign rvalid         = valid_q[raddr];
  assign {rtag, rdata}  = lines_q[raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between fetch and MemCtrl's instruction port.
// One word per line; hits answer next cycle, misses refill through MISS/RESP.
module icache
  import icache_pkg::*;
#(
  parameter  int unsigned INDEX_BITS = ICACHE_INDEX_BITS,
  localparam int unsigned TAG_W      = 30 - INDEX_BITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rdy,
  input  logic flush,
  icache_if.slave bus
);

  ic_state_e       state_q, state_d;
  logic            cancel_q, cancel_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_inst_q, if_inst_d;
  logic [XLEN-1:0] if_pc_out_q, if_pc_out_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]      req_tag, fill_tag, line_tag;
  logic [XLEN-1:0]       line_data;
  logic                  line_valid;
  logic                  ready_c, accept_c, hit_c, fill_c;

  assign req_idx  = bus.if_pc[INDEX_BITS+1:2];
  assign req_tag  = bus.if_pc[XLEN-1:INDEX_BITS+2];
  assign fill_idx = pc_q[INDEX_BITS+1:2];
  assign fill_tag = pc_q[XLEN-1:INDEX_BITS+2];

  assign ready_c  = (state_q == IC_IDLE) && rst_n && !flush;
  assign accept_c = bus.if_req && ready_c && rdy;
  assign hit_c    = line_valid && (line_tag == req_tag);
  assign fill_c   = (state_q == IC_MISS) && bus.mem_done && rdy && rst_n;

  icache_line_ram #(.INDEX_BITS(INDEX_BITS)) u_line_ram (
    .clk    (clk),
    .clr    (!rst_n),
    .we     (fill_c),
    .waddr  (fill_idx),
    .wtag   (fill_tag),
    .wdata  (bus.mem_data),
    .raddr  (req_idx),
    .rvalid (line_valid),
    .rtag   (line_tag),
    .rdata  (line_data)
  );

  always_comb begin
    state_d     = state_q;
    cancel_d    = cancel_q;
    pc_d        = pc_q;
    if_valid_d  = 1'b0;
    if_inst_d   = if_inst_q;
    if_pc_out_d = if_pc_out_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    case (state_q)
      IC_IDLE: begin
        cancel_d = 1'b0;
        if (accept_c) begin
          pc_d = bus.if_pc;
          if (hit_c) begin
            if_valid_d  = 1'b1;
            if_inst_d   = line_data;
            if_pc_out_d = bus.if_pc;
          end else begin
            state_d    = IC_MISS;
            mem_req_d  = 1'b1;
            mem_addr_d = {bus.if_pc[XLEN-1:2], 2'b00};
          end
        end
      end
      IC_MISS: begin
        // MemCtrl cannot abort, so a flush only suppresses the eventual response.
        cancel_d = cancel_q || flush;
        if (bus.mem_done) begin
          state_d     = IC_RESP;
          mem_req_d   = 1'b0;
          if_valid_d  = !(cancel_q || flush);
          if_inst_d   = bus.mem_data;
          if_pc_out_d = pc_q;
        end
      end
      IC_RESP: begin
        state_d  = IC_IDLE;
        cancel_d = 1'b0;
      end
      default: state_d = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IC_IDLE;
      cancel_q    <= 1'b0;
      pc_q        <= '0;
      if_valid_q  <= 1'b0;
      if_inst_q   <= '0;
      if_pc_out_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      cancel_q    <= cancel_d;
      pc_q        <= pc_d;
      if_valid_q  <= if_valid_d;
      if_inst_q   <= if_inst_d;
      if_pc_out_q <= if_pc_out_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign bus.if_ready  = ready_c;
  assign bus.if_valid  = if_valid_q && rdy && !flush;
  assign bus.if_inst   = if_inst_q;
  assign bus.if_pc_out = if_pc_out_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: driver predicts responses from a line-level
// reference model and queues them; a negedge monitor pops and compares.
module tb_icache;
  import icache_pkg::*;

  localparam int unsigned IB    = 6;
  localparam int unsigned LINES = 1 << IB;

  logic clk = 1'b0;
  logic rst_n, rdy, flush;

  icache_if bus();

  icache #(.INDEX_BITS(IB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: which memory word each line currently mirrors.
  bit          ref_v [LINES];
  logic [31:0] ref_t [LINES];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  function automatic int line_of(input logic [31:0] pc);
    return int'((pc / 4) % LINES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (4 * LINES);
  endfunction

  function automatic bit ref_hit(input logic [31:0] pc);
    return ref_v[line_of(pc)] && (ref_t[line_of(pc)] == tag_of(pc));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input int at);
    exp_t e;
    e.pc = pc; e.inst = mem_word(pc); e.cyc = at;
    exp_q.push_back(e);
  endtask

  // fmode: 0 none, 1 flush in the cycle after acceptance, 2 flush with mem_done
  task automatic fetch(input logic [31:0] pc, input int fmode, input bit stall, input int delay);
    bit cancel = 1'b0;
    logic [31:0] a = {pc[31:2], 2'b00};
    #1;
    check("ready_before_req", 32'(bus.if_ready), 32'd1);
    bus.if_req = 1'b1;
    bus.if_pc  = pc;
    if (ref_hit(pc)) begin
      if (fmode != 1) push_exp(pc, cyc + 1);
      step();
      bus.if_req = 1'b0;
      check("no_memreq_on_hit", 32'(bus.mem_req), 32'd0);
      if (fmode == 1) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
    end else begin
      step();
      bus.if_req = 1'b0;
      check("memreq_after_miss", 32'(bus.mem_req), 32'd1);
      check("mem_addr", bus.mem_addr, a);
      check("ready_low_in_miss", 32'(bus.if_ready), 32'd0);
      if (fmode == 1) begin
        flush  = 1'b1;
        cancel = 1'b1;
      end
      repeat (delay - 1) begin
        step();
        flush = 1'b0;
        check("memreq_held", 32'(bus.mem_req), 32'd1);
        check("mem_addr_held", bus.mem_addr, a);
      end
      if (stall) begin
        rdy = 1'b0;
        repeat (3) begin
          step();
          check("stall_memreq", 32'(bus.mem_req), 32'd1);
          check("stall_addr", bus.mem_addr, a);
          check("stall_no_valid", 32'(bus.if_valid), 32'd0);
        end
        rdy = 1'b1;
      end
      bus.mem_done = 1'b1;
      bus.mem_data = mem_word(pc);
      if (fmode == 2) begin
        flush  = 1'b1;
        cancel = 1'b1;
      end
      ref_v[line_of(pc)] = 1'b1;
      ref_t[line_of(pc)] = tag_of(pc);
      if (!cancel) push_exp(pc, cyc + 1);
      step();
      bus.mem_done = 1'b0;
      bus.mem_data = $urandom;
      flush        = 1'b0;
      #1;
      check("memreq_low_after_done", 32'(bus.mem_req), 32'd0);
      check("ready_low_in_resp", 32'(bus.if_ready), 32'd0);
      step();
      check("ready_back", 32'(bus.if_ready), 32'd1);
    end
  endtask

  // Monitor: every if_valid must match the head of the queue, on time.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      $display("FAIL missing_resp: no if_valid for pc %08h expected at cycle %0d", e.pc, e.cyc);
    end
    if (rst_n === 1'b1 && bus.if_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid: got pc %08h inst %08h, required no response (cycle %0d)",
                 bus.if_pc_out, bus.if_inst, cyc);
      end else begin
        e = exp_q.pop_front();
        check("resp_pc", bus.if_pc_out, e.pc);
        check("resp_inst", bus.if_inst, e.inst);
        check("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    bus.if_req = 1'b0; bus.if_pc = '0; bus.mem_done = 1'b0; bus.mem_data = '0;
    foreach (ref_v[i]) begin ref_v[i] = 1'b0; ref_t[i] = '0; end
    step();
    step();
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_if_inst", bus.if_inst, 32'd0);
    check("rst_if_pc_out", bus.if_pc_out, 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_if_ready", 32'(bus.if_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(bus.if_ready), 32'd1);

    fetch(32'h0000_0000, 0, 1'b0, 4);
    fetch(32'h0000_0004, 0, 1'b0, 2);
    fetch(32'h0000_0000, 0, 1'b0, 1);
    fetch(32'h0000_0004, 0, 1'b0, 1);
    fetch(32'h0000_0100, 0, 1'b0, 3);
    fetch(32'h0000_0000, 0, 1'b0, 2);
    fetch(32'h0000_0200, 1, 1'b0, 3);
    fetch(32'h0000_0200, 0, 1'b0, 1);
    fetch(32'h0000_0300, 2, 1'b0, 2);
    fetch(32'h0000_0300, 1, 1'b0, 1);
    fetch(32'h0000_0400, 0, 1'b1, 2);

    // Request under flush is ignored even though it would hit.
    flush = 1'b1; bus.if_req = 1'b1; bus.if_pc = 32'h0000_0400;
    #1;
    check("ready_low_in_flush", 32'(bus.if_ready), 32'd0);
    step();
    check("no_memreq_flush_req", 32'(bus.mem_req), 32'd0);
    flush = 1'b0; bus.if_req = 1'b0;
    step();

    // Reset in the middle of a refill, followed by a stray mem_done.
    bus.if_req = 1'b1; bus.if_pc = 32'h0000_0500;
    step();
    bus.if_req = 1'b0;
    check("rst_case_memreq", 32'(bus.mem_req), 32'd1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    foreach (ref_v[i]) ref_v[i] = 1'b0;
    #1;
    check("memreq_after_midrst", 32'(bus.mem_req), 32'd0);
    check("ready_after_midrst", 32'(bus.if_ready), 32'd1);
    bus.mem_done = 1'b1; bus.mem_data = 32'hDEAD_BEEF;
    step();
    bus.mem_done = 1'b0;
    step();
    fetch(32'h0000_0004, 0, 1'b0, 1);

    // Randomized traffic over a small aliasing address pool.
    for (int n = 0; n < 250; n++) begin
      logic [31:0] pc;
      int r, fm;
      pc = 32'($urandom_range(0, 3)) * 32'h100 + 32'($urandom_range(0, 7)) * 32'h4;
      r  = int'($urandom_range(0, 99));
      fm = (r < 8) ? 1 : ((r < 14) ? 2 : 0);
      fetch(pc, fm, ($urandom_range(0, 9) == 0), int'($urandom_range(1, 5)));
      if ($urandom_range(0, 3) == 0) begin
        bus.mem_done = ($urandom_range(0, 1) == 1);
        bus.mem_data = $urandom;
        step();
        bus.mem_done = 1'b0;
      end
    end

    repeat (4) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
